// File: rtl/addsub_pkg.sv
// Shared types and default widths for the multi-word add/subtract sequencer.
package addsub_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_slice.sv
// One-word combinational add/subtract slice; the sequencer reuses it for every word.
// msb_cin (carry into the word MSB) is only produced when ADDSUB_SEQ_OVERFLOW_EN is defined.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  msb_cin
);

  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   total;

  // NOTE: always_comb uses blocking '=' so later lines see the values just computed.
  always_comb begin
    b_eff = sub ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, cin};
  end

  assign sum  = total[DATA_WIDTH-1:0];
  assign cout = total[DATA_WIDTH];

`ifdef ADDSUB_SEQ_OVERFLOW_EN
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out by XOR.
  assign msb_cin = a[DATA_WIDTH-1] ^ b_eff[DATA_WIDTH-1] ^ sum[DATA_WIDTH-1];
`else
  assign msb_cin = 1'b0;
`endif

endmodule

// File: rtl/addsub_sequencer.sv
// Word-serial add/subtract of two NUM_WORDS x DATA_WIDTH operands, one word per cycle, LSW first.
// Define ADDSUB_SEQ_OVERFLOW_EN to build signed-overflow detection; otherwise overflow is tied 0.
module addsub_sequencer
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_WORDS  = DEFAULT_NUM_WORDS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] b,
  input  logic                            sub,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] result,
  output logic                            carry_out,
  output logic                            overflow
);

  localparam int TOTAL_W = DATA_WIDTH * NUM_WORDS;
  localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               sub_q;
  logic               carry_out_q;
  logic [TOTAL_W-1:0] a_q, b_q, result_q;

  logic                  accept, running, last_word;
  logic [DATA_WIDTH-1:0] a_word, b_word, sum_word;
  logic                  slice_cout, slice_msb_cin;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign running   = (state_q == RUN);
  assign last_word = (idx_q == LAST_IDX);

  assign a_word = a_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign b_word = b_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

  addsub_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
    .a       (a_word),
    .b       (b_word),
    .sub     (sub_q),
    .cin     (carry_q),
    .sum     (sum_word),
    .cout    (slice_cout),
    .msb_cin (slice_msb_cin)
  );

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sub_q   <= sub;
        idx_q   <= '0;
        carry_q <= sub;
      end else if (running) begin
        result_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] <= sum_word;
        carry_q <= slice_cout;
        idx_q   <= idx_q + 1'b1;
        if (last_word) carry_out_q <= slice_cout;
      end
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;

`ifdef ADDSUB_SEQ_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   overflow_q <= 1'b0;
    else if (running && last_word) overflow_q <= slice_msb_cin ^ slice_cout;
  end

  assign overflow = overflow_q;
`else
  logic unused_msb_cin;
  assign unused_msb_cin = slice_msb_cin;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed self-checking bench for addsub_sequencer at DATA_WIDTH=8, NUM_WORDS=4.
module tb_addsub_sequencer;

  localparam int DW = 8;
  localparam int NW = 4;
  localparam int LAT_BOUND = 20;

`ifdef ADDSUB_SEQ_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   a, b;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   result;
  logic          carry_out;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  addsub_sequencer #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < LAT_BOUND) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [31:0] er, input logic eco, input logic eov);
    int lat;
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    check({name, " in_ready_before"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    a = ~av; b = $urandom; sub = ~sv;
    check({name, " in_ready_running"}, in_ready, 0);
    wait_out_valid(lat);
    check({name, " latency"}, lat, NW);
    check({name, " result"}, result, er);
    check({name, " carry_out"}, carry_out, eco);
    check({name, " overflow"}, overflow, eov);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " out_valid_after_hs"}, out_valid, 0);
    check({name, " in_ready_after_hs"}, in_ready, 1);
    check({name, " result_kept_idle"}, result, er);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset carry_out", carry_out, 0);
    check("reset overflow", overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    run_op("add_ff_1",      32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("sub_100_1",     32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
    run_op("sub_0_1",       32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("add_7fff_1",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, EXP_OVF);
    run_op("sub_8000_1",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, EXP_OVF);

    // Consumer stalls in DONE while a new request is offered.
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out_valid(lat);
    check("hold latency", lat, NW);
    check("hold result", result, 32'h2345_6789);
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold out_valid", out_valid, 1);
      check("hold in_ready", in_ready, 0);
      check("hold result_stable", result, 32'h2345_6789);
      check("hold carry_out_stable", carry_out, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold released in_ready", in_ready, 1);
    check("hold released out_valid", out_valid, 0);
    step();
    check("hold no_queued_request", in_ready, 1);

    // Reset two edges after acceptance aborts the operation.
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    check("abort result", result, 0);
    check("abort carry_out", carry_out, 0);
    check("abort overflow", overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("abort no_handshake", out_valid, 0);
    run_op("post_abort_add", 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 32'hDFAE_BFF0, 1'b0, 1'b0);

    // Back-to-back requests with the consumer always ready.
    out_ready = 1'b1;
    a = 32'h0000_0001; b = 32'h0000_0002; sub = 1'b0; in_valid = 1'b1;
    check("b2b in_ready_first", in_ready, 1);
    step();
    a = 32'h0000_0005; b = 32'h0000_0007; sub = 1'b1;
    check("b2b in_ready_running", in_ready, 0);
    wait_out_valid(lat);
    check("b2b first latency", lat, NW);
    check("b2b first result", result, 32'h0000_0003);
    check("b2b first carry_out", carry_out, 0);
    step();
    check("b2b handshake out_valid", out_valid, 0);
    check("b2b handshake in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("b2b second accepted", in_ready, 0);
    wait_out_valid(lat);
    check("b2b second latency", lat, NW);
    check("b2b second result", result, 32'hFFFF_FFFE);
    check("b2b second carry_out", carry_out, 0);
    check("b2b second overflow", overflow, 0);
    step();
    check("b2b final in_ready", in_ready, 1);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_sequencer.md
ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, width of one datapath word.
REQ-002 The block SHALL have parameter NUM_WORDS, default 4, word count per operand; legal range 2..16.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  request valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port a  input  DATA_WIDTH*NUM_WORDS  minuend/augend.
REQ-008 The block SHALL have port b  input  DATA_WIDTH*NUM_WORDS  subtrahend/addend.
REQ-009 The block SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port result  output  DATA_WIDTH*NUM_WORDS  sum/difference, modulo 2^(DATA_WIDTH*NUM_WORDS).
REQ-013 The block SHALL have port carry_out  output  1  final carry; for subtract, 1 = no borrow.
REQ-014 The block SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 exactly in IDLE; a request is accepted on an edge where in_valid && in_ready.
REQ-017 On acceptance, a, b and sub SHALL be registered; later input changes have no effect.
REQ-018 On acceptance, the word index SHALL be cleared to 0, the carry register loaded with sub, and the state set to RUN.
REQ-019 In RUN, each cycle SHALL process word k (LSW first): b word inverted when sub=1, added to a word k plus carry register; the sum goes to result word k and the carry-out to the carry register.
REQ-020 After word NUM_WORDS-1, the state SHALL be DONE; out_valid rises exactly NUM_WORDS edges after the acceptance edge.
REQ-021 In DONE, out_valid SHALL be 1 and result, carry_out and overflow SHALL be held stable until out_ready is sampled 1.
REQ-022 On an edge with out_valid && out_ready, the state SHALL return to IDLE; the next request may be accepted on the following edge, not the same edge.
REQ-023 overflow SHALL be the XOR of the carry into and the carry out of the MSB of the top word.
REQ-024 in_valid while in RUN or DONE SHALL be ignored, with no queuing.
REQ-025 result, carry_out and overflow SHALL keep their last values in IDLE.

Reset
REQ-026 When rst_n=0, the state SHALL become IDLE immediately: in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, word index=0, carry register=0.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no output handshake; after release, the first edge may accept a new request.

Configuration
REQ-028 With macro ADDSUB_SEQ_OVERFLOW_EN defined, overflow SHALL be computed per REQ-023.
REQ-029 Without ADDSUB_SEQ_OVERFLOW_EN, the overflow port SHALL remain present and be tied to 0, and no MSB-carry tracking logic SHALL be built.

Structure
REQ-030 Package addsub_pkg SHALL hold the FSM state enum type and the localparam default widths.
REQ-031 Per-word arithmetic SHALL be a combinational sub-module addsub_slice (DATA_WIDTH, inputs a, b, sub, cin; outputs sum, cout, msb_cin), instantiated once and reused every RUN cycle.

Verification (DATA_WIDTH=8, NUM_WORDS=4)
REQ-032 The bench SHALL check: add 0x000000FF + 0x00000001 -> result 0x00000100, carry_out 0, overflow 0, out_valid 4 edges after acceptance.
REQ-033 The bench SHALL check: sub 0x00000100 - 0x00000001 -> 0x000000FF, carry_out 1; and sub 0x00000000 - 0x00000001 -> 0xFFFFFFFF, carry_out 0.
REQ-034 The bench SHALL check: add 0x7FFFFFFF + 0x00000001 -> 0x80000000, overflow 1 with the macro defined and 0 without it.
REQ-035 The bench SHALL check: out_ready held 0 for 3 cycles in DONE -> result stable, in_ready 0, a new in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-036 The bench SHALL check: rst_n pulsed low 2 edges after acceptance -> out_valid 0, in_ready 1 immediately, result 0; the next request completes correctly.
REQ-037 The bench SHALL check: back-to-back requests with out_ready tied 1 -> the second is accepted one edge after the first output handshake.
